// File: rtl/urp_pcie_pkt_fifo.sv
// urp_pcie_pkt_fifo
// Synchronous packet FIFO between the PCIe TLP formatter and the link-side
// transmit path. Valid/ready on both sides, per-word last flag,
// first-word-fall-through read port, registered status flags, word and
// packet occupancy counts, and a synchronous flush.
// Optional build macro: URP_PCIE_PKT_FIFO_SAF_EN selects store-and-forward
// release (a packet is presented only once its last word is stored).
module urp_pcie_pkt_fifo #(
    parameter int DEPTH_LG2    = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int AFULL_THRES  = (1 << DEPTH_LG2) - 1,
    parameter int AEMPTY_THRES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_last_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_last_o,
    output logic                  afull_o,
    output logic                  aempty_o,
    output logic [DEPTH_LG2:0]    cnt_o,
    output logic [DEPTH_LG2:0]    pkt_cnt_o
);

    localparam int              DEPTH    = 1 << DEPTH_LG2;
    localparam int              PW       = DEPTH_LG2 + 1;
    localparam logic [PW-1:0]   AFULL_T  = PW'(AFULL_THRES);
    localparam logic [PW-1:0]   AEMPTY_T = PW'(AEMPTY_THRES);
    localparam logic [PW-1:0]   ONE      = PW'(1);

    // Storage is deliberately left unreset; contents are qualified by m_valid_o.
    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic                  mem_last [DEPTH];

    logic [PW-1:0] wrptr_q, rdptr_q, wrptr_nxt, rdptr_nxt;
    logic [PW-1:0] cnt_q, cnt_nxt, pkt_q, pkt_nxt;
    logic          s_ready_q, afull_q, aempty_q, empty_q;
    logic          empty_nxt, full_nxt, afull_nxt, aempty_nxt;
    logic          push, pop, m_valid;

    assign push = s_valid_i & s_ready_q;
    assign pop  = m_valid & m_ready_i;

`ifdef URP_PCIE_PKT_FIFO_SAF_EN
    // Escape from the full-with-no-complete-packet deadlock: once the FIFO
    // fills without a stored last word, words flow cut-through until the
    // next last word leaves the FIFO.
    logic esc_q, esc_nxt, stuck;

    assign stuck   = ~s_ready_q & (pkt_q == '0);
    assign m_valid = ~empty_q & ((pkt_q != '0) | esc_q | stuck);

    // Escape flag next state: flush and a last-word pop end it, a stuck full FIFO starts it.
    always_comb begin
        esc_nxt = esc_q;
        if (flush_i)
            esc_nxt = 1'b0;
        else if (pop & m_last_o)
            esc_nxt = 1'b0;
        else if (stuck)
            esc_nxt = 1'b1;
    end

    // Escape flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            esc_q <= 1'b0;
        else
            esc_q <= esc_nxt;
    end
`else
    assign m_valid = ~empty_q;
`endif

    assign m_valid_o = m_valid;
    assign m_data_o  = mem_data[rdptr_q[DEPTH_LG2-1:0]];
    assign m_last_o  = mem_last[rdptr_q[DEPTH_LG2-1:0]];
    assign s_ready_o = s_ready_q;
    assign afull_o   = afull_q;
    assign aempty_o  = aempty_q;
    assign cnt_o     = cnt_q;
    assign pkt_cnt_o = pkt_q;

    // Next-state pointers, counts and flags; flush overrides any handshake.
    always_comb begin
        wrptr_nxt = wrptr_q + (push ? ONE : '0);
        rdptr_nxt = rdptr_q + (pop ? ONE : '0);
        pkt_nxt   = pkt_q + ((push & s_last_i) ? ONE : '0) - ((pop & m_last_o) ? ONE : '0);
        if (flush_i) begin
            wrptr_nxt = '0;
            rdptr_nxt = '0;
            pkt_nxt   = '0;
        end
        cnt_nxt    = wrptr_nxt - rdptr_nxt;
        empty_nxt  = (wrptr_nxt == rdptr_nxt);
        full_nxt   = (wrptr_nxt[DEPTH_LG2-1:0] == rdptr_nxt[DEPTH_LG2-1:0]) &&
                     (wrptr_nxt[DEPTH_LG2] != rdptr_nxt[DEPTH_LG2]);
        afull_nxt  = (cnt_nxt >= AFULL_T);
        aempty_nxt = (cnt_nxt <= AEMPTY_T);
    end

    // Control state register; reset discards contents by clearing the pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrptr_q   <= '0;
            rdptr_q   <= '0;
            cnt_q     <= '0;
            pkt_q     <= '0;
            s_ready_q <= 1'b1;
            afull_q   <= 1'b0;
            aempty_q  <= 1'b1;
            empty_q   <= 1'b1;
        end else begin
            wrptr_q   <= wrptr_nxt;
            rdptr_q   <= rdptr_nxt;
            cnt_q     <= cnt_nxt;
            pkt_q     <= pkt_nxt;
            s_ready_q <= ~full_nxt;
            afull_q   <= afull_nxt;
            aempty_q  <= aempty_nxt;
            empty_q   <= empty_nxt;
        end
    end

    // Payload write on an accepted push; a push dropped by flush is never stored.
    always_ff @(posedge clk) begin
        if (push & ~flush_i) begin
            mem_data[wrptr_q[DEPTH_LG2-1:0]] <= s_data_i;
            mem_last[wrptr_q[DEPTH_LG2-1:0]] <= s_last_i;
        end
    end

endmodule

// File: tb/tb_urp_pcie_pkt_fifo.sv
// tb_urp_pcie_pkt_fifo
// Self-checking bench for urp_pcie_pkt_fifo at DEPTH_LG2=2, DATA_WIDTH=32.
// Honours URP_PCIE_PKT_FIFO_SAF_EN to select the store-and-forward expectations.
module tb_urp_pcie_pkt_fifo;

    localparam int DEPTH = 4;
`ifdef URP_PCIE_PKT_FIFO_SAF_EN
    localparam bit SAF = 1'b1;
`else
    localparam bit SAF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, s_valid, s_last, m_ready;
    logic [31:0] s_data;
    logic        s_ready, m_valid, m_last, afull, aempty;
    logic [31:0] m_data;
    logic [2:0]  cnt, pkt_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: words in order, {last, data}, plus the escape state.
    logic [32:0] mq[$];
    bit          esc;

    urp_pcie_pkt_fifo #(.DEPTH_LG2(2), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush_i(flush),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data), .s_last_i(s_last),
        .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .m_last_o(m_last),
        .afull_o(afull), .aempty_o(aempty), .cnt_o(cnt), .pkt_cnt_o(pkt_cnt)
    );

    always #5 clk = ~clk;

    function automatic int count_last();
        int n = 0;
        foreach (mq[i]) n += int'(mq[i][32]);
        return n;
    endfunction

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0; s_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mq.delete();
        esc = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        step();
        tests_run++; if (s_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_s_ready got=%0b exp=1", s_ready); end
        tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_m_valid got=%0b exp=0", m_valid); end
        tests_run++; if (cnt !== 3'd0) begin tests_failed++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
        tests_run++; if (aempty !== 1'b1) begin tests_failed++; $display("FAIL reset_aempty got=%0b exp=1", aempty); end
        tests_run++; if (afull !== 1'b0) begin tests_failed++; $display("FAIL reset_afull got=%0b exp=0", afull); end
        tests_run++; if (pkt_cnt !== 3'd0) begin tests_failed++; $display("FAIL reset_pkt_cnt got=%0d exp=0", pkt_cnt); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_last = 1'b0; s_data = 32'hA0 + 32'(i);
            step();
            tests_run++; if (cnt !== 3'(i + 1)) begin tests_failed++; $display("FAIL fill_cnt[%0d] got=%0d exp=%0d", i, cnt, i + 1); end
            tests_run++; if (afull !== ((i + 1) >= 3)) begin tests_failed++; $display("FAIL fill_afull[%0d] got=%0b exp=%0b", i, afull, (i + 1) >= 3); end
            tests_run++; if (m_valid !== (SAF ? (i == 3) : 1'b1)) begin tests_failed++; $display("FAIL fill_m_valid[%0d] got=%0b", i, m_valid); end
        end
        tests_run++; if (s_ready !== 1'b0) begin tests_failed++; $display("FAIL full_s_ready got=%0b exp=0", s_ready); end
        tests_run++; if (m_data !== 32'hA0) begin tests_failed++; $display("FAIL full_head got=%h exp=a0", m_data); end
        s_data = 32'hA4;
        step();
        s_valid = 1'b0;
        tests_run++; if (cnt !== 3'd4) begin tests_failed++; $display("FAIL full_reject_cnt got=%0d exp=4", cnt); end
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests_run++; if (m_valid !== 1'b1 || m_data !== 32'hA0 + 32'(i)) begin tests_failed++; $display("FAIL drain[%0d] valid=%0b data=%h exp=%h", i, m_valid, m_data, 32'hA0 + 32'(i)); end
            step();
            if (i == 0) begin
                tests_run++; if (s_ready !== 1'b1) begin tests_failed++; $display("FAIL pop_from_full_s_ready got=%0b exp=1", s_ready); end
            end
        end
        m_ready = 1'b0;
        tests_run++; if (m_valid !== 1'b0 || cnt !== 3'd0 || aempty !== 1'b1) begin tests_failed++; $display("FAIL drained valid=%0b cnt=%0d aempty=%0b exp 0/0/1", m_valid, cnt, aempty); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] eq[$];
        logic [31:0] exp_d;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1; s_last = 1'b1; s_data = 32'hB0 + 32'(i);
            eq.push_back(s_data);
            step();
        end
        m_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            s_data = 32'hC0 + 32'(k);
            exp_d = eq.pop_front();
            eq.push_back(s_data);
            tests_run++; if (m_valid !== 1'b1 || m_data !== exp_d) begin tests_failed++; $display("FAIL b2b_data[%0d] valid=%0b got=%h exp=%h", k, m_valid, m_data, exp_d); end
            step();
            tests_run++; if (cnt !== 3'd2 || pkt_cnt !== 3'd2) begin tests_failed++; $display("FAIL b2b_cnt[%0d] cnt=%0d pkt=%0d exp=2/2", k, cnt, pkt_cnt); end
        end
        s_valid = 1'b0; m_ready = 1'b0;
    endtask

    task automatic test_packet_release();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_last = (i == 2); s_data = 32'hD0 + 32'(i);
            step();
            tests_run++; if (m_valid !== (SAF ? (i == 2) : 1'b1)) begin tests_failed++; $display("FAIL pkt_m_valid[%0d] got=%0b", i, m_valid); end
            tests_run++; if (pkt_cnt !== 3'(i == 2)) begin tests_failed++; $display("FAIL pkt_cnt_push[%0d] got=%0d exp=%0d", i, pkt_cnt, i == 2); end
        end
        s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tests_run++; if (m_data !== 32'hD0 + 32'(i) || m_last !== (i == 2)) begin tests_failed++; $display("FAIL pkt_pop[%0d] data=%h last=%0b", i, m_data, m_last); end
            step();
            tests_run++; if (pkt_cnt !== 3'(i != 2)) begin tests_failed++; $display("FAIL pkt_cnt_pop[%0d] got=%0d exp=%0d", i, pkt_cnt, i != 2); end
        end
        m_ready = 1'b0;
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_last = (i == 1); s_data = 32'hE0 + 32'(i);
            step();
        end
        tests_run++; if (cnt !== 3'd3) begin tests_failed++; $display("FAIL flush_pre_cnt got=%0d exp=3", cnt); end
        s_data = 32'hDEAD; s_last = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; s_valid = 1'b0;
        tests_run++; if (cnt !== 3'd0 || pkt_cnt !== 3'd0) begin tests_failed++; $display("FAIL flush_cnt cnt=%0d pkt=%0d exp=0/0", cnt, pkt_cnt); end
        tests_run++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_hs valid=%0b ready=%0b exp=0/1", m_valid, s_ready); end
        tests_run++; if (aempty !== 1'b1 || afull !== 1'b0) begin tests_failed++; $display("FAIL flush_flags aempty=%0b afull=%0b exp=1/0", aempty, afull); end
        s_valid = 1'b1; s_last = 1'b1; s_data = 32'h55;
        step();
        s_valid = 1'b0;
        tests_run++; if (m_valid !== 1'b1 || m_data !== 32'h55) begin tests_failed++; $display("FAIL flush_next_word valid=%0b data=%h exp=1/55", m_valid, m_data); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1; s_last = 1'b0; s_data = 32'hF0 + 32'(i);
            step();
        end
        s_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        tests_run++; if (cnt !== 3'd0 || m_valid !== 1'b0 || s_ready !== 1'b1 || pkt_cnt !== 3'd0) begin tests_failed++; $display("FAIL async_reset cnt=%0d valid=%0b ready=%0b pkt=%0d", cnt, m_valid, s_ready, pkt_cnt); end
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        esc = 1'b0;
    endtask

    task automatic test_random();
        bit          sv, mr, sl, fl, exp_ready, exp_valid;
        logic [31:0] sd;
        logic [32:0] head;
        int          nl;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            sv = ($urandom_range(0, 3) != 0);
            mr = ($urandom_range(0, 2) != 0);
            sl = ($urandom_range(0, 2) == 0);
            fl = ($urandom_range(0, 39) == 0);
            sd = $urandom;
            s_valid = sv; m_ready = mr; s_last = sl; s_data = sd; flush = fl;
            nl = count_last();
            if (SAF && mq.size() == DEPTH && nl == 0) esc = 1'b1;
            exp_ready = (mq.size() < DEPTH);
            exp_valid = (mq.size() > 0) && (!SAF || nl > 0 || esc);
            tests_run++; if (s_ready !== exp_ready) begin tests_failed++; $display("FAIL rnd_s_ready[%0d] got=%0b exp=%0b", c, s_ready, exp_ready); end
            tests_run++; if (m_valid !== exp_valid) begin tests_failed++; $display("FAIL rnd_m_valid[%0d] got=%0b exp=%0b", c, m_valid, exp_valid); end
            tests_run++; if (cnt !== 3'(mq.size()) || pkt_cnt !== 3'(nl)) begin tests_failed++; $display("FAIL rnd_counts[%0d] cnt=%0d pkt=%0d exp=%0d/%0d", c, cnt, pkt_cnt, mq.size(), nl); end
            tests_run++; if (afull !== (mq.size() >= 3) || aempty !== (mq.size() <= 1)) begin tests_failed++; $display("FAIL rnd_flags[%0d] afull=%0b aempty=%0b size=%0d", c, afull, aempty, mq.size()); end
            if (exp_valid) begin
                tests_run++; if ({m_last, m_data} !== mq[0]) begin tests_failed++; $display("FAIL rnd_head[%0d] got=%h exp=%h", c, {m_last, m_data}, mq[0]); end
            end
            @(posedge clk);
            if (fl) begin
                mq.delete();
                esc = 1'b0;
            end else begin
                if (exp_valid && mr) begin
                    head = mq.pop_front();
                    if (head[32]) esc = 1'b0;
                end
                if (sv && exp_ready) mq.push_back({sl, sd});
            end
            @(negedge clk);
        end
        s_valid = 1'b0; m_ready = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_back_to_back();
        test_packet_release();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
